// File: rtl/matrix_mem_responder_if.sv
// Bus bundle between the matrix_mem_responder and its users (host + top_control_fsm).
// The master modport is the requesting side; the slave modport is the responder.
interface matrix_mem_responder_if #(
    parameter int N = 3,
    parameter int W = 8
);
    // Host load stream
    logic                  host_load_start;
    logic                  host_wr_valid;
    logic                  host_wr_ready;
    logic signed [W-1:0]   host_wr_data;
    logic                  mem_loaded;

    // Operand read ports
    logic [31:0]           read_addr_A;
    logic                  read_en_A;
    logic signed [W-1:0]   A_out;
    logic [31:0]           read_addr_B;
    logic                  read_en_B;
    logic signed [W-1:0]   B_out;

    // Result write port
    logic [31:0]           write_addr_C;
    logic                  write_en_C;
    logic signed [2*W-1:0] C_in;

    // Host dump stream
    logic                  host_dump_start;
    logic                  dump_valid;
    logic                  dump_ready;
    logic signed [2*W-1:0] dump_data;
    logic                  dump_last;

    // Status and statistics
    logic                  oob_err;
    logic [31:0]           rd_count;
    logic [31:0]           wr_count;

    modport master (
        output host_load_start, host_wr_valid, host_wr_data,
        output read_addr_A, read_en_A, read_addr_B, read_en_B,
        output write_addr_C, write_en_C, C_in,
        output host_dump_start, dump_ready,
        input  host_wr_ready, mem_loaded, A_out, B_out,
        input  dump_valid, dump_data, dump_last,
        input  oob_err, rd_count, wr_count
    );

    modport slave (
        input  host_load_start, host_wr_valid, host_wr_data,
        input  read_addr_A, read_en_A, read_addr_B, read_en_B,
        input  write_addr_C, write_en_C, C_in,
        input  host_dump_start, dump_ready,
        output host_wr_ready, mem_loaded, A_out, B_out,
        output dump_valid, dump_data, dump_last,
        output oob_err, rd_count, wr_count
    );
endinterface

// File: rtl/matrix_mem_responder.sv
// Operand/result store for the sparse matrix-multiply accelerator.
// Holds A and B (loaded by the host), serves one-cycle-latency operand reads,
// captures C result writes and streams C back to the host.
// Optional macro MEM_ACCESS_CNT_EN builds the rd_count/wr_count access counters;
// without it both counters read as 0.
module matrix_mem_responder #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_mem_responder_if.slave bus
);
    localparam int NN    = N * N;
    localparam int TOTAL = 2 * NN;
    localparam int AW    = (NN > 1) ? $clog2(NN) : 1;
    localparam int IW    = $clog2(TOTAL);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  mem_loaded_q, mem_loaded_d;
    logic                  oob_err_q, oob_err_d;
    logic [AW-1:0]         rd_addr_a_q, rd_addr_a_d;
    logic [AW-1:0]         rd_addr_b_q, rd_addr_b_d;
    logic                  rd_live_q, rd_live_d;
    logic signed [2*W-1:0] c_mem_q [NN];
    logic signed [2*W-1:0] c_mem_d [NN];

    logic signed [W-1:0]   a_mem_q [NN];
    logic signed [W-1:0]   b_mem_q [NN];
    logic                  a_we, b_we;
    logic [AW-1:0]         load_a_idx, load_b_idx;

    logic                  a_rd_ok, b_rd_ok, c_wr_addr_ok;

    assign a_rd_ok      = bus.read_addr_A  < 32'(NN);
    assign b_rd_ok      = bus.read_addr_B  < 32'(NN);
    assign c_wr_addr_ok = bus.write_addr_C < 32'(NN);
    assign load_a_idx   = idx_q[AW-1:0];
    assign load_b_idx   = AW'(idx_q - IW'(NN));

    // Next-state logic: FSM, shared index, sticky error, read address capture and C updates
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mem_loaded_d = mem_loaded_q;
        oob_err_d    = oob_err_q;
        c_mem_d      = c_mem_q;
        a_we         = 1'b0;
        b_we         = 1'b0;
        rd_live_d    = 1'b1;
        rd_addr_a_d  = a_rd_ok ? bus.read_addr_A[AW-1:0] : '0;
        rd_addr_b_d  = b_rd_ok ? bus.read_addr_B[AW-1:0] : '0;

        if (bus.read_en_A && !a_rd_ok) oob_err_d = 1'b1;
        if (bus.read_en_B && !b_rd_ok) oob_err_d = 1'b1;

        if (bus.write_en_C) begin
            if (state_q == SERVE && c_wr_addr_ok) begin
                c_mem_d[bus.write_addr_C[AW-1:0]] = bus.C_in;
            end else begin
                oob_err_d = 1'b1;
            end
        end

        case (state_q)
            LOAD: begin
                if (bus.host_wr_valid) begin
                    if (idx_q < IW'(NN)) a_we = 1'b1;
                    else                 b_we = 1'b1;
                    if (idx_q == IW'(TOTAL - 1)) begin
                        state_d      = SERVE;
                        idx_d        = '0;
                        mem_loaded_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SERVE: begin
                if (bus.host_dump_start) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                if (bus.dump_ready) begin
                    if (idx_q == IW'(NN - 1)) begin
                        state_d = SERVE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (bus.host_load_start) begin
            state_d      = LOAD;
            idx_d        = '0;
            oob_err_d    = 1'b0;
            mem_loaded_d = 1'b0;
            a_we         = 1'b0;
            b_we         = 1'b0;
            for (int i = 0; i < NN; i++) c_mem_d[i] = '0;
        end
    end

    // Control and C-store registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            mem_loaded_q <= 1'b0;
            oob_err_q    <= 1'b0;
            rd_addr_a_q  <= '0;
            rd_addr_b_q  <= '0;
            rd_live_q    <= 1'b0;
            c_mem_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mem_loaded_q <= mem_loaded_d;
            oob_err_q    <= oob_err_d;
            rd_addr_a_q  <= rd_addr_a_d;
            rd_addr_b_q  <= rd_addr_b_d;
            rd_live_q    <= rd_live_d;
            c_mem_q      <= c_mem_d;
        end
    end

    // Operand stores: written only by the load stream, deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (!reset && a_we) a_mem_q[load_a_idx] <= bus.host_wr_data;
        if (!reset && b_we) b_mem_q[load_b_idx] <= bus.host_wr_data;
    end

    assign bus.host_wr_ready = (state_q == LOAD);
    assign bus.mem_loaded    = mem_loaded_q;
    assign bus.oob_err       = oob_err_q;
    assign bus.A_out         = rd_live_q ? a_mem_q[rd_addr_a_q] : '0;
    assign bus.B_out         = rd_live_q ? b_mem_q[rd_addr_b_q] : '0;
    assign bus.dump_valid    = (state_q == DUMP);
    assign bus.dump_data     = (state_q == DUMP) ? c_mem_q[idx_q[AW-1:0]] : '0;
    assign bus.dump_last     = (state_q == DUMP) && (idx_q == IW'(NN - 1));

`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    // Access counters: read strobes per cycle and accepted C writes, cleared by a new load
    always_comb begin
        rd_count_d = rd_count_q + 32'(bus.read_en_A) + 32'(bus.read_en_B);
        wr_count_d = wr_count_q;
        if (bus.write_en_C && state_q == SERVE && c_wr_addr_ok) wr_count_d = wr_count_q + 32'd1;
        if (bus.host_load_start) begin
            rd_count_d = '0;
            wr_count_d = '0;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
`else
    assign bus.rd_count = '0;
    assign bus.wr_count = '0;
`endif
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed bench for matrix_mem_responder: load/read, C write and dump,
// out-of-range handling, backpressure, restart/reset and access counters.
module tb_matrix_mem_responder;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int NN = N * N;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matrix_mem_responder_if #(.N(N), .W(W)) bus ();
    matrix_mem_responder #(.N(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    logic signed [W-1:0]   a_vals [NN];
    logic signed [W-1:0]   b_vals [NN];
    logic signed [2*W-1:0] c_exp  [NN];
    logic [31:0]           rd_exp, wr_exp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.host_load_start = 1'b0;
        bus.host_wr_valid   = 1'b0;
        bus.host_wr_data    = '0;
        bus.read_addr_A     = '0;
        bus.read_en_A       = 1'b0;
        bus.read_addr_B     = '0;
        bus.read_en_B       = 1'b0;
        bus.write_addr_C    = '0;
        bus.write_en_C      = 1'b0;
        bus.C_in            = '0;
        bus.host_dump_start = 1'b0;
        bus.dump_ready      = 1'b0;
    endtask

    // Full 18-word load of a_vals then b_vals, checking mem_loaded timing
    task automatic do_load();
        bus.host_load_start = 1'b1;
        step();
        bus.host_load_start = 1'b0;
        for (int i = 0; i < 2 * NN; i++) begin
            bus.host_wr_valid = 1'b1;
            if (i < NN) bus.host_wr_data = a_vals[i];
            else        bus.host_wr_data = b_vals[i - NN];
            step();
            if (i == 2 * NN - 2) begin
                vectors++;
                if (bus.mem_loaded !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL mem_loaded_early got %0b want 0", bus.mem_loaded);
                end
            end
        end
        bus.host_wr_valid = 1'b0;
        vectors++;
        if (bus.mem_loaded !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mem_loaded got %0b want 1", bus.mem_loaded);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({bus.host_wr_ready, bus.mem_loaded, bus.dump_valid, bus.dump_last, bus.oob_err} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got %b want 00000",
                     {bus.host_wr_ready, bus.mem_loaded, bus.dump_valid, bus.dump_last, bus.oob_err});
        end
        vectors++;
        if (bus.A_out !== 8'sd0 || bus.B_out !== 8'sd0 || bus.dump_data !== 16'sd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data got A=%0d B=%0d D=%0d want 0 0 0", bus.A_out, bus.B_out, bus.dump_data);
        end
        vectors++;
        if (bus.rd_count !== 32'd0 || bus.wr_count !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts got rd=%0d wr=%0d want 0 0", bus.rd_count, bus.wr_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_read();
        do_load();
        vectors++;
        if (bus.host_wr_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_ready_after_load got %0b want 0", bus.host_wr_ready);
        end
        for (int k = 0; k < NN; k++) begin
            bus.read_addr_A = 32'(k);
            bus.read_en_A   = 1'b1;
            bus.read_addr_B = 32'(NN - 1 - k);
            bus.read_en_B   = 1'b1;
            step();
            vectors++;
            if (bus.A_out !== a_vals[k]) begin
                miscompares++;
                $display("[TB] FAIL read_A[%0d] got %0d want %0d", k, bus.A_out, a_vals[k]);
            end
            vectors++;
            if (bus.B_out !== b_vals[NN - 1 - k]) begin
                miscompares++;
                $display("[TB] FAIL read_B[%0d] got %0d want %0d", NN - 1 - k, bus.B_out, b_vals[NN - 1 - k]);
            end
        end
        bus.read_en_A = 1'b0;
        bus.read_en_B = 1'b0;
        vectors++;
        if (bus.oob_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL oob_after_reads got %0b want 0", bus.oob_err);
        end
    endtask

    task automatic test_write_dump();
        for (int i = 0; i < NN; i++) c_exp[i] = 16'sd0;
        c_exp[2] = 16'sd1234;
        c_exp[8] = -16'sd5;
        bus.write_en_C   = 1'b1;
        bus.write_addr_C = 32'd2;
        bus.C_in         = 16'sd555;
        step();
        bus.C_in = 16'sd1234;
        step();
        bus.write_addr_C = 32'd8;
        bus.C_in         = -16'sd5;
        step();
        bus.write_en_C      = 1'b0;
        bus.host_dump_start = 1'b1;
        step();
        bus.host_dump_start = 1'b0;
        bus.dump_ready      = 1'b1;
        for (int k = 0; k < NN; k++) begin
            vectors++;
            if (bus.dump_valid !== 1'b1 || bus.dump_data !== c_exp[k]) begin
                miscompares++;
                $display("[TB] FAIL dump_word[%0d] got v=%0b d=%0d want v=1 d=%0d", k, bus.dump_valid, bus.dump_data, c_exp[k]);
            end
            vectors++;
            if (bus.dump_last !== (k == NN - 1)) begin
                miscompares++;
                $display("[TB] FAIL dump_last[%0d] got %0b want %0b", k, bus.dump_last, (k == NN - 1));
            end
            step();
        end
        bus.dump_ready = 1'b0;
        vectors++;
        if (bus.dump_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dump_end got valid=%0b want 0", bus.dump_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.host_dump_start = 1'b1;
        step();
        bus.host_dump_start = 1'b0;
        bus.dump_ready      = 1'b1;
        for (int k = 0; k < NN; k++) begin
            if (k == 2) begin
                bus.dump_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    vectors++;
                    if (bus.dump_valid !== 1'b1 || bus.dump_data !== 16'sd1234) begin
                        miscompares++;
                        $display("[TB] FAIL stall[%0d] got v=%0b d=%0d want v=1 d=1234", s, bus.dump_valid, bus.dump_data);
                    end
                end
                bus.dump_ready = 1'b1;
            end
            vectors++;
            if (bus.dump_data !== c_exp[k] || bus.dump_last !== (k == NN - 1)) begin
                miscompares++;
                $display("[TB] FAIL bp_word[%0d] got d=%0d last=%0b want d=%0d last=%0b",
                         k, bus.dump_data, bus.dump_last, c_exp[k], (k == NN - 1));
            end
            step();
        end
        bus.dump_ready = 1'b0;
        vectors++;
        if (bus.dump_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_end got valid=%0b want 0", bus.dump_valid);
        end
    endtask

    task automatic test_oob();
        bus.write_en_C   = 1'b1;
        bus.write_addr_C = 32'd12;
        bus.C_in         = 16'sd99;
        step();
        bus.write_en_C = 1'b0;
        vectors++;
        if (bus.oob_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL oob_write got %0b want 1", bus.oob_err);
        end
        bus.host_dump_start = 1'b1;
        step();
        bus.host_dump_start = 1'b0;
        bus.dump_ready      = 1'b1;
        for (int k = 0; k < NN; k++) begin
            vectors++;
            if (bus.dump_data !== c_exp[k]) begin
                miscompares++;
                $display("[TB] FAIL oob_c_unchanged[%0d] got %0d want %0d", k, bus.dump_data, c_exp[k]);
            end
            step();
        end
        bus.dump_ready      = 1'b0;
        bus.host_load_start = 1'b1;
        step();
        bus.host_load_start = 1'b0;
        vectors++;
        if (bus.oob_err !== 1'b0 || bus.mem_loaded !== 1'b0 || bus.host_wr_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL load_clears got oob=%0b loaded=%0b rdy=%0b want 0 0 1",
                     bus.oob_err, bus.mem_loaded, bus.host_wr_ready);
        end
        bus.read_addr_A = 32'd15;
        bus.read_en_A   = 1'b0;
        step();
        vectors++;
        if (bus.oob_err !== 1'b0 || bus.A_out !== 8'sd7) begin
            miscompares++;
            $display("[TB] FAIL oob_no_strobe got oob=%0b A=%0d want 0 7", bus.oob_err, bus.A_out);
        end
        bus.read_addr_A = 32'd9;
        bus.read_en_A   = 1'b1;
        step();
        bus.read_en_A = 1'b0;
        vectors++;
        if (bus.oob_err !== 1'b1 || bus.A_out !== 8'sd7) begin
            miscompares++;
            $display("[TB] FAIL oob_read_A got oob=%0b A=%0d want 1 7", bus.oob_err, bus.A_out);
        end
        bus.host_load_start = 1'b1;
        step();
        bus.host_load_start = 1'b0;
        bus.read_addr_A     = 32'd0;
        bus.read_addr_B     = 32'd9;
        bus.read_en_B       = 1'b1;
        step();
        bus.read_en_B = 1'b0;
        vectors++;
        if (bus.oob_err !== 1'b1 || bus.B_out !== 8'sd3) begin
            miscompares++;
            $display("[TB] FAIL oob_read_B got oob=%0b B=%0d want 1 3", bus.oob_err, bus.B_out);
        end
        bus.read_addr_B     = 32'd0;
        bus.host_load_start = 1'b1;
        step();
        bus.host_load_start = 1'b0;
        vectors++;
        if (bus.oob_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL oob_cleared got %0b want 0", bus.oob_err);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 5; i++) begin
            bus.host_wr_valid = 1'b1;
            bus.host_wr_data  = 8'sd99;
            step();
        end
        bus.host_wr_valid = 1'b0;
        vectors++;
        if (bus.mem_loaded !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL partial_load got loaded=%0b want 0", bus.mem_loaded);
        end
        do_load();
        for (int k = 0; k < NN; k++) begin
            bus.read_addr_A = 32'(k);
            bus.read_addr_B = 32'(k);
            step();
            vectors++;
            if (bus.A_out !== a_vals[k] || bus.B_out !== b_vals[k]) begin
                miscompares++;
                $display("[TB] FAIL restart_read[%0d] got A=%0d B=%0d want %0d %0d", k, bus.A_out, bus.B_out, a_vals[k], b_vals[k]);
            end
        end
        bus.host_dump_start = 1'b1;
        step();
        bus.host_dump_start = 1'b0;
        bus.dump_ready      = 1'b1;
        for (int k = 0; k < NN; k++) begin
            vectors++;
            if (bus.dump_data !== 16'sd0) begin
                miscompares++;
                $display("[TB] FAIL c_cleared[%0d] got %0d want 0", k, bus.dump_data);
            end
            step();
        end
        bus.dump_ready = 1'b0;
    endtask

    task automatic test_counters();
`ifdef MEM_ACCESS_CNT_EN
        rd_exp = 32'd54;
        wr_exp = 32'd9;
`else
        rd_exp = 32'd0;
        wr_exp = 32'd0;
`endif
        do_load();
        for (int i = 0; i < 3 * NN; i++) begin
            bus.read_addr_A  = 32'(i % NN);
            bus.read_addr_B  = 32'(i % NN);
            bus.read_en_A    = 1'b1;
            bus.read_en_B    = 1'b1;
            bus.write_en_C   = (i < NN);
            bus.write_addr_C = 32'(i % NN);
            bus.C_in         = 16'(i * 100 - 300);
            step();
        end
        bus.read_en_A  = 1'b0;
        bus.read_en_B  = 1'b0;
        bus.write_en_C = 1'b0;
        vectors++;
        if (bus.rd_count !== rd_exp) begin
            miscompares++;
            $display("[TB] FAIL rd_count got %0d want %0d", bus.rd_count, rd_exp);
        end
        vectors++;
        if (bus.wr_count !== wr_exp) begin
            miscompares++;
            $display("[TB] FAIL wr_count got %0d want %0d", bus.wr_count, wr_exp);
        end
    endtask

    task automatic test_reset_mid_dump();
        bus.host_dump_start = 1'b1;
        step();
        bus.host_dump_start = 1'b0;
        bus.dump_ready      = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        vectors++;
        if (bus.dump_valid !== 1'b0 || bus.dump_data !== 16'sd0 || bus.mem_loaded !== 1'b0 || bus.A_out !== 8'sd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_dump got v=%0b d=%0d loaded=%0b A=%0d want 0 0 0 0",
                     bus.dump_valid, bus.dump_data, bus.mem_loaded, bus.A_out);
        end
        reset          = 1'b0;
        bus.dump_ready = 1'b0;
        bus.host_dump_start = 1'b1;
        step();
        bus.host_dump_start = 1'b0;
        vectors++;
        if (bus.dump_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_ignores_dump got valid=%0b want 0", bus.dump_valid);
        end
        bus.read_addr_A = 32'd4;
        bus.read_en_A   = 1'b1;
        step();
        bus.read_en_A = 1'b0;
        vectors++;
        if (bus.A_out !== 8'sd6) begin
            miscompares++;
            $display("[TB] FAIL a_kept_over_reset got %0d want 6", bus.A_out);
        end
        bus.write_en_C   = 1'b1;
        bus.write_addr_C = 32'd1;
        step();
        bus.write_en_C = 1'b0;
        vectors++;
        if (bus.oob_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL write_in_idle got oob=%0b want 1", bus.oob_err);
        end
    endtask

    initial begin
        a_vals = '{8'sd7, 8'sd8, 8'sd9, 8'sd0, 8'sd6, 8'sd5, 8'sd2, 8'sd0, 8'sd4};
        b_vals = '{8'sd3, 8'sd5, 8'sd1, 8'sd4, 8'sd2, 8'sd7, 8'sd6, 8'sd0, 8'sd8};
        for (int i = 0; i < NN; i++) c_exp[i] = 16'sd0;
        test_reset();
        test_load_read();
        test_write_dump();
        test_backpressure();
        test_oob();
        test_restart();
        test_counters();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/matrix_mem_responder.md
# matrix_mem_responder

Memory-side responder for the sparse matrix-multiply accelerator. It answers `top_control_fsm` operand reads on the A and B ports with a fixed one-cycle latency, and captures result writes on the C port. It also gives the host a valid/ready stream to load A and B, and a second stream to dump C after `done_all`. It replaces the behavioural memory model in the system benches and is the synthesizable operand/result store on FPGA.

## Interface
Parameters:
- `N`, 3: matrix dimension. Each matrix holds N*N entries, row-major.
- `W`, 8: operand width. C entries are 2W bits wide.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset: synchronous, active-high.
- `host_load_start`  in  1  pulse: begin loading A then B.
- `host_wr_valid`  in  1  load word valid.
- `host_wr_ready`  out  1  load word accepted.
- `host_wr_data`  in  W  signed load word.
- `mem_loaded`  out  1  A and B fully loaded.
- `read_addr_A`  in  32  A read address.
- `read_en_A`  in  1  A read strobe.
- `A_out`  out  W  signed A data.
- `read_addr_B`  in  32  B read address.
- `read_en_B`  in  1  B read strobe.
- `B_out`  out  W  signed B data.
- `write_addr_C`  in  32  C write address.
- `write_en_C`  in  1  C write strobe.
- `C_in`  in  2W  signed C data.
- `host_dump_start`  in  1  pulse: stream C out.
- `dump_valid`  out  1  dump word valid.
- `dump_ready`  in  1  host accepts dump word.
- `dump_data`  out  2W  C entry at the current dump index.
- `dump_last`  out  1  marks entry N*N-1.
- `oob_err`  out  1  sticky out-of-range access flag.
- `rd_count`  out  32  accepted A+B read strobes.
- `wr_count`  out  32  accepted C writes.

## Operation
- The FSM has four states: IDLE, LOAD, SERVE, DUMP. The shared index counter `idx` spans 0..2N*N-1.
- **`host_load_start` in any state:**
  - goes to LOAD
  - sets `idx`=0
  - clears every C entry and `oob_err`
  - drops `mem_loaded`
  - takes priority over all other events, and aborts any dump in progress
- **LOAD:**
  - `host_wr_ready`=1.
  - On `host_wr_valid`, the word is written to A[idx] when idx<N*N, otherwise to B[idx-N*N]. `idx` then increments.
  - The word at idx=2N*N-1 moves the FSM to SERVE, sets `mem_loaded`=1 and resets `idx` to 0.
- **Operand reads (every state):**
  - Each cycle, `read_addr_A` and `read_addr_B` are registered.
  - An address ≥ N*N is replaced by 0.
  - `A_out` and `B_out` are driven from the registered addresses, so outputs update every cycle whether or not `read_en` is asserted.
  - An out-of-range address with its `read_en` high sets `oob_err`.
- **C writes:**
  - Accepted only in SERVE, when `write_en_C` is high and `write_addr_C` < N*N: C[addr] <= C_in.
  - An out-of-range write is dropped and sets `oob_err`.
  - `write_en_C` outside SERVE is dropped and sets `oob_err`.
  - A second write to the same address overwrites the first.
- **`host_dump_start`:**
  - Acts only in SERVE: goes to DUMP with `idx`=0. It is ignored in any other state.
- **DUMP:**
  - `dump_valid`=1 and `dump_data`=C[idx]. `dump_last` = (idx==N*N-1).
  - On `dump_ready`, `idx` increments. The last handshake returns the FSM to SERVE.
  - While `dump_ready` is low, `dump_data` is held.
- No arithmetic is performed. Data is stored and returned bit-exact, sign preserved.

## Timing
- **Read latency:** the address presented at edge k appears on `A_out`/`B_out` after edge k+1, i.e. valid in cycle k+1.
- **Load:** one word per cycle with valid held high. 2N*N words take 2N*N cycles, and `mem_loaded` is high the cycle after the last accept.
- **C write:** visible in the dump one cycle after the write edge.
- **Dump:** `dump_valid` rises the cycle after `host_dump_start`. With `dump_ready` held high, N*N words stream in N*N cycles.
- **Reset:**
  - State goes to IDLE.
  - These outputs reset to 0: `A_out`, `B_out`, `host_wr_ready`, `mem_loaded`, `dump_valid`, `dump_data`, `dump_last`, `oob_err`, `rd_count`, `wr_count`.
  - C entries clear to 0. A and B contents are not reset.
- Reset during LOAD or DUMP abandons the transfer with no partial-completion flag.

## Configuration
- Macro `MEM_ACCESS_CNT_EN`.
- **Defined:**
  - `rd_count` increments by the number of high `read_en_A`/`read_en_B` strobes in a cycle (0, 1 or 2).
  - `wr_count` increments per accepted C write.
  - Both counters clear on reset and on `host_load_start`, and wrap at 2^32.
- **Undefined:** both ports are tied to 0 and no counter logic is built.

## Test plan
- **Load and read:** load A={7,8,9,0,6,5,2,0,4}, B={3,5,1,4,2,7,6,0,8}. Then `read_addr_A`=4 with `read_en_A` → `A_out`=6 one cycle later; `read_addr_B`=7 → `B_out`=0; `mem_loaded`=1.
- **Write and dump:** write C[2]=1234 and C[8]=-5, then dump with `dump_ready`=1 → words 0,0,1234,0,0,0,0,0,-5, with `dump_last` only on the 9th word.
- **Out of range:**
  - `read_addr_A`=9 with `read_en_A` → `A_out`=7 and `oob_err`=1.
  - A write to address 12 → C unchanged.
  - A new `host_load_start` clears `oob_err`.
- **Backpressure:** hold `dump_ready`=0 for 3 cycles on word 2 → `dump_data`=1234 stable, `dump_valid`=1. Releasing it completes 9 words.
- **Restart and reset:** `host_load_start` after 5 load words → `idx` restarts and only a full 18-word load sets `mem_loaded`. Reset mid-DUMP → `dump_valid`=0 next cycle and state IDLE.
- **Counters:** with `MEM_ACCESS_CNT_EN`, a full 3x3 run (27 A + 27 B reads, 9 writes) → `rd_count`=54, `wr_count`=9. Without the macro → both 0.
